// File: rtl/gate_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_tester_pkg
// Description : Shared definitions for the 2-input logic gate tester:
//               gate function encodings, FSM state encoding, vector count
//               and a gate_sel legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_tester_pkg;

    // Gate function encodings carried on gate_sel (6 and 7 are illegal)
    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;

    // Exhaustive test of a 2-input gate
    localparam int NUM_VECTORS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic gate_sel_legal(input logic [2:0] sel);
        return (sel <= GATE_XNOR);
    endfunction

endpackage : gate_tester_pkg
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational reference gate. Produces the value a correct
//               gate of the selected function would output for (a, b).
// Ports       : gate_sel - gate function (gate_tester_pkg encodings)
//               a, b     - operands currently driven to the gate under test
//               expected - reference output (0 for illegal selections)
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import gate_tester_pkg::*;
(
    input  logic [2:0] gate_sel,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (gate_sel)
            GATE_AND:  expected =   a & b;
            GATE_OR:   expected =   a | b;
            GATE_NAND: expected = ~(a & b);
            GATE_NOR:  expected = ~(a | b);
            GATE_XOR:  expected =   a ^ b;
            GATE_XNOR: expected = ~(a ^ b);
            default:   expected = 1'b0;
        endcase
    end

endmodule : gate_ref_model
`default_nettype wire

// File: rtl/logic_gate_tester.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_tester
// Description : Exhaustively exercises an external 2-input gate. Each vector
//               {a,b} = 0..3 is held HOLD_CYCLES cycles to settle, then one
//               CHECK cycle compares y against the reference gate.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, gate_sel   - run request and expected gate function
//               a, b / y          - stimulus to / response from gate under test
//               busy, done, pass  - run status and result
//               err_count, err_vec- mismatch count and per-vector flags
//               sel_err           - captured gate_sel was illegal
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_tester
    import gate_tester_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_vec,
    output logic       sel_err
);

    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [1:0] c_LAST_VEC  = 2'(NUM_VECTORS - 1);

    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic [1:0] r_vec;
    logic [2:0] r_gate_sel;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_err_vec;
    logic       r_sel_err;

    logic       w_expected;
    logic       w_mismatch;
    logic [2:0] w_err_count_next;
    logic [3:0] w_err_vec_next;

    gate_ref_model u_ref (
        .gate_sel (r_gate_sel),
        .a        (r_a),
        .b        (r_b),
        .expected (w_expected)
    );

    // Error bookkeeping as it will stand after the current CHECK cycle; the
    // final pass verdict must include the last vector's result.
    always_comb begin
        w_mismatch       = (y != w_expected);
        w_err_count_next = r_err_count + {2'b00, w_mismatch};
        w_err_vec_next   = r_err_vec | (w_mismatch ? (4'b0001 << r_vec) : 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= 4'd0;
            r_vec       <= 2'd0;
            r_gate_sel  <= 3'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_err_vec   <= 4'd0;
            r_sel_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_gate_sel  <= gate_sel;
                        r_pass      <= 1'b0;
                        r_err_count <= 3'd0;
                        r_err_vec   <= 4'd0;
                        if (gate_sel_legal(gate_sel)) begin
                            r_state    <= ST_DRIVE;
                            r_vec      <= 2'd0;
                            r_hold_cnt <= 4'd0;
                            r_a        <= 1'b0;
                            r_b        <= 1'b0;
                            r_busy     <= 1'b1;
                            r_sel_err  <= 1'b0;
                        end else begin
                            r_state   <= ST_FINISH;
                            r_sel_err <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end

                ST_DRIVE: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end

                ST_CHECK: begin
                    r_err_count <= w_err_count_next;
                    r_err_vec   <= w_err_vec_next;
                    if (r_vec == c_LAST_VEC) begin
                        r_state <= ST_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_pass  <= (w_err_count_next == 3'd0) && !r_sel_err;
                    end else begin
                        r_state      <= ST_DRIVE;
                        r_vec        <= r_vec + 2'd1;
                        {r_a, r_b}   <= r_vec + 2'd1;
                        r_hold_cnt   <= 4'd0;
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_vec   = r_err_vec;
    assign sel_err   = r_sel_err;

endmodule : logic_gate_tester
`default_nettype wire

// File: tb/tb_logic_gate_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_tester
// Description : Self-checking bench for logic_gate_tester. Two instances
//               (HOLD_CYCLES 3 and 1) each drive a modelled gate under test.
//               Expected run results are queued at start and compared when
//               done is observed; vector sequencing is checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_tester;
    import gate_tester_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [2];
    logic [2:0] gsel    [2];
    logic [2:0] gut     [2];
    logic       y       [2];
    logic       a_o     [2];
    logic       b_o     [2];
    logic       busy    [2];
    logic       done    [2];
    logic       pass    [2];
    logic [2:0] errc    [2];
    logic [3:0] errv    [2];
    logic       sel_err [2];

    typedef struct {
        logic       pass;
        logic [2:0] errc;
        logic [3:0] errv;
        logic       sel_err;
        int         done_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Truth table of every gate function, used both as the gate under test
    // and as the bench's expected reference.
    function automatic logic gate_fn(input logic [2:0] f, input logic ia, input logic ib);
        case (f)
            3'd0:    return   ia & ib;
            3'd1:    return   ia | ib;
            3'd2:    return ~(ia & ib);
            3'd3:    return ~(ia | ib);
            3'd4:    return   ia ^ ib;
            3'd5:    return ~(ia ^ ib);
            default: return 1'b0;
        endcase
    endfunction

    assign y[0] = gate_fn(gut[0], a_o[0], b_o[0]);
    assign y[1] = gate_fn(gut[1], a_o[1], b_o[1]);

    logic_gate_tester #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start[0]), .gate_sel(gsel[0]),
        .a(a_o[0]), .b(b_o[0]), .y(y[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(errc[0]), .err_vec(errv[0]), .sel_err(sel_err[0])
    );

    logic_gate_tester #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .gate_sel(gsel[1]),
        .a(a_o[1]), .b(b_o[1]), .y(y[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(errc[1]), .err_vec(errv[1]), .sel_err(sel_err[1])
    );

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int all_outs(input int idx);
        return int'({a_o[idx], b_o[idx], busy[idx], done[idx], pass[idx],
                     errc[idx], errv[idx], sel_err[idx]});
    endfunction

    // One complete run on instance idx: sel is the expected function given to
    // the tester, gut_f the function the modelled gate actually implements.
    task automatic run_test(input int idx, input logic [2:0] sel, input logic [2:0] gut_f,
                            input bit hold_start, input string tag);
        exp_t       e;
        exp_t       got_e;
        int         h;
        int         span;
        int         done_n;
        int         bad;
        bit         legal;
        logic [1:0] v;
        logic [1:0] ev;
        logic       eb;

        h      = (idx == 0) ? 3 : 1;
        span   = 4 * (h + 1);
        legal  = (sel <= 3'd5);
        e.errc = 3'd0;
        e.errv = 4'd0;
        if (legal) begin
            for (int i = 0; i < 4; i++) begin
                v = 2'(i);
                if (gate_fn(gut_f, v[1], v[0]) != gate_fn(sel, v[1], v[0])) begin
                    e.errv[i] = 1'b1;
                    e.errc    = e.errc + 3'd1;
                end
            end
        end
        e.sel_err = !legal;
        e.pass    = legal && (e.errc == 3'd0);
        e.done_n  = legal ? span : 0;

        gut[idx] = gut_f;
        @(negedge clk);
        gsel[idx]  = sel;
        start[idx] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);

        done_n = -1;
        bad    = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (legal && n < span) begin
                ev = 2'(n / (h + 1));
                eb = 1'b1;
            end else begin
                ev = 2'd0;
                eb = 1'b0;
            end
            if ({a_o[idx], b_o[idx]} != ev || busy[idx] != eb) bad++;
            if (n == 0) begin
                gsel[idx] = 3'($urandom_range(0, 7));
                if (!hold_start) start[idx] = 1'b0;
            end
            if (done[idx]) begin
                done_n = n;
                break;
            end
        end

        // Cycle after FINISH: back in IDLE even if start was held through FINISH
        @(negedge clk);
        chk_eq({tag, "_done_single"}, int'(done[idx]), 0);
        chk_eq({tag, "_idle_after"}, int'(busy[idx]), 0);
        start[idx] = 1'b0;
        @(negedge clk);

        got_e = sb_q.pop_front();
        chk_eq({tag, "_done_at"}, done_n, got_e.done_n);
        chk_eq({tag, "_seq_bad_cycles"}, bad, 0);
        chk_eq({tag, "_pass"}, int'(pass[idx]), int'(got_e.pass));
        chk_eq({tag, "_err_count"}, int'(errc[idx]), int'(got_e.errc));
        chk_eq({tag, "_err_vec"}, int'(errv[idx]), int'(got_e.errv));
        chk_eq({tag, "_sel_err"}, int'(sel_err[idx]), int'(got_e.sel_err));
    endtask

    initial begin
        int ndone;
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        gsel[0]  = 3'd0;
        gsel[1]  = 3'd0;
        gut[0]   = 3'd3;
        gut[1]   = 3'd4;
        repeat (2) @(negedge clk);
        chk_eq("reset_dut3", all_outs(0), 0);
        chk_eq("reset_dut1", all_outs(1), 0);
        rst = 1'b0;

        run_test(0, 3'd3, 3'd3, 1'b0, "nor_ok");
        run_test(0, 3'd0, 3'd3, 1'b0, "and_vs_nor");

        // Reset during vector 2 DRIVE abandons the run with no done
        gut[0] = 3'd3;
        @(negedge clk);
        gsel[0]  = 3'd3;
        start[0] = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        chk_eq("pre_rst_vec2", int'({a_o[0], b_o[0]}), 2);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mid_rst_outs", all_outs(0), 0);
        rst   = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk_eq("rst_no_done", ndone, 0);
        run_test(0, 3'd3, 3'd3, 1'b0, "after_rst");

        run_test(0, 3'd3, 3'd3, 1'b1, "start_held");
        run_test(0, 3'd6, 3'd3, 1'b0, "sel6");
        run_test(0, 3'd7, 3'd3, 1'b0, "sel7");
        run_test(1, 3'd4, 3'd4, 1'b0, "xor_h1");
        run_test(1, 3'd5, 3'd4, 1'b0, "xnor_vs_xor_h1");

        for (int r = 0; r < 4; r++) begin
            run_test(r % 2, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_logic_gate_tester
`default_nettype wire
